// File: rtl/camera_sequencer_pkg.sv
// camera_seq_pkg: shared state encoding, output bundle and helpers
// for the OV7670 bring-up sequencer.
package camera_seq_pkg;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_PWDN   = 3'd1;
  localparam logic [2:0] STATE_RESET  = 3'd2;
  localparam logic [2:0] STATE_SETTLE = 3'd3;
  localparam logic [2:0] STATE_INIT   = 3'd4;
  localparam logic [2:0] STATE_RUN    = 3'd5;
  localparam logic [2:0] STATE_FAULT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = STATE_IDLE,
    ST_PWDN   = STATE_PWDN,
    ST_RESET  = STATE_RESET,
    ST_SETTLE = STATE_SETTLE,
    ST_INIT   = STATE_INIT,
    ST_RUN    = STATE_RUN,
    ST_FAULT  = STATE_FAULT
  } seq_state_t;

  typedef struct packed {
    logic pwdn;
    logic cam_rst_n;
    logic cfg_rst;
    logic start;
    logic cap_en;
    logic ready;
    logic fault;
  } seq_out_t;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic seq_out_t state_outputs(
    input seq_state_t s
  );
    seq_out_t o;
    o = '0;
    case (s)
      ST_PWDN: begin
        o.pwdn    = 1'b1;
        o.cfg_rst = 1'b1;
      end
      ST_RESET: o.cfg_rst = 1'b1;
      ST_SETTLE: begin
        o.cam_rst_n = 1'b1;
        o.cfg_rst   = 1'b1;
      end
      ST_INIT: begin
        o.cam_rst_n = 1'b1;
        o.start     = 1'b1;
      end
      ST_RUN: begin
        o.cam_rst_n = 1'b1;
        o.cap_en    = 1'b1;
        o.ready     = 1'b1;
      end
      ST_FAULT: begin
        o.pwdn    = 1'b1;
        o.cfg_rst = 1'b1;
        o.fault   = 1'b1;
      end
      default: begin
        o.pwdn    = 1'b1;
        o.cfg_rst = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/camera_sequencer_timer.sv
// seq_timer: loadable down-counter that parks at zero;
// expired is high whenever the count is zero.
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/camera_sequencer.sv
// camera_sequencer: OV7670 power-up / SCCB init / run supervisor.
// Define CAMERA_SEQ_STATS_EN to add frame and retry counters.
module camera_sequencer
  import camera_seq_pkg::*;
#(
  parameter int unsigned PWDN_CYCLES   = 1_000,
  parameter int unsigned RST_CYCLES    = 100_000,
  parameter int unsigned SETTLE_CYCLES = 300_000,
  parameter int unsigned INIT_TIMEOUT  = 10_000_000,
  parameter int unsigned FRAME_TIMEOUT = 10_000_000,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_cam_done,
  input  logic        i_vsync_sync,
  output logic        o_cam_reset,
  output logic        o_cam_pwdn,
  output logic        o_cfg_rst,
  output logic        o_cam_start,
  output logic        o_capture_en,
  output logic        o_ready,
  output logic        o_fault,
`ifdef CAMERA_SEQ_STATS_EN
  output logic [15:0] o_frame_cnt,
  output logic [3:0]  o_retry_cnt,
`endif
  output logic [2:0]  o_state
);

  localparam int unsigned CYC_MAX = max2(
    max2(max2(PWDN_CYCLES, RST_CYCLES),
         max2(SETTLE_CYCLES, INIT_TIMEOUT)),
    FRAME_TIMEOUT);
  localparam int unsigned TW = $clog2(CYC_MAX + 1);
  localparam int unsigned RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Loads are N-1 so each timed state lasts exactly N cycles.
  localparam logic [TW-1:0] LD_PWDN  = TW'(PWDN_CYCLES - 1);
  localparam logic [TW-1:0] LD_RST   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LD_SETL  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LD_INIT  = TW'(INIT_TIMEOUT - 1);
  localparam logic [TW-1:0] LD_FRAME = TW'(FRAME_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  seq_state_t    state_q;
  seq_state_t    state_d;
  logic [RW-1:0] retry_q;
  logic [RW-1:0] retry_d;
  logic          init_first_q;
  logic          vsync_q;
  logic          vs_rise;
  logic          retry_fail;
  logic          tmr_load;
  logic          tmr_exp;
  logic [TW-1:0] tmr_val;
  seq_out_t      out_q;

  assign vs_rise = i_vsync_sync & ~vsync_q;

  always_comb begin
    state_d    = state_q;
    retry_d    = (state_q == ST_IDLE) ? '0 : retry_q;
    retry_fail = 1'b0;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_PWDN;
        ST_PWDN:   if (tmr_exp) state_d = ST_RESET;
        ST_RESET:  if (tmr_exp) state_d = ST_SETTLE;
        ST_SETTLE: if (tmr_exp) state_d = ST_INIT;
        ST_INIT: begin
          // done may be stale from before cfg_rst released
          if (i_cam_done && !init_first_q) begin
            state_d = ST_RUN;
          end else if (tmr_exp) begin
            retry_fail = 1'b1;
          end
        end
        ST_RUN:    if (!vs_rise && tmr_exp) retry_fail = 1'b1;
        ST_FAULT:  state_d = ST_FAULT;
        default:   state_d = ST_IDLE;
      endcase
      if (retry_fail) begin
        if (retry_q < RETRY_LIM) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_PWDN;
        end else begin
          state_d = ST_FAULT;
        end
      end
    end
  end

  always_comb begin
    tmr_load = (state_d != state_q) ||
               (state_q == ST_RUN && vs_rise);
    unique case (state_d)
      ST_PWDN:   tmr_val = LD_PWDN;
      ST_RESET:  tmr_val = LD_RST;
      ST_SETTLE: tmr_val = LD_SETL;
      ST_INIT:   tmr_val = LD_INIT;
      ST_RUN:    tmr_val = LD_FRAME;
      default:   tmr_val = '0;
    endcase
  end

  seq_timer #(
    .W (TW)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (tmr_load),
    .i_value   (tmr_val),
    .o_expired (tmr_exp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      retry_q      <= '0;
      init_first_q <= 1'b0;
      vsync_q      <= 1'b0;
      out_q        <= state_outputs(ST_IDLE);
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      init_first_q <= (state_d == ST_INIT) &&
                      (state_q != ST_INIT);
      vsync_q      <= i_vsync_sync;
      out_q        <= state_outputs(state_d);
    end
  end

  assign o_cam_pwdn   = out_q.pwdn;
  assign o_cam_reset  = out_q.cam_rst_n;
  assign o_cfg_rst    = out_q.cfg_rst;
  assign o_cam_start  = out_q.start;
  assign o_capture_en = out_q.cap_en;
  assign o_ready      = out_q.ready;
  assign o_fault      = out_q.fault;
  assign o_state      = state_q;

`ifdef CAMERA_SEQ_STATS_EN
  logic [15:0] frame_q;
  logic [3:0]  rcnt_q;
  logic        retry_take;

  // INIT/RUN only reach PWDN through a granted retry
  assign retry_take = (state_q == ST_INIT || state_q == ST_RUN) &&
                      (state_d == ST_PWDN);

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q == ST_IDLE) begin
      frame_q <= '0;
      rcnt_q  <= '0;
    end else begin
      if (state_q == ST_RUN && vs_rise) begin
        frame_q <= frame_q + 16'd1;
      end
      if (retry_take && rcnt_q != 4'hF) begin
        rcnt_q <= rcnt_q + 4'd1;
      end
    end
  end

  assign o_frame_cnt = frame_q;
  assign o_retry_cnt = rcnt_q;
`endif

endmodule
